// File: rtl/radiometer_cal_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// radiometer_cal_sequencer_pkg
// Shared definitions for the radiometer calibration sequencer:
//   - cal_state_t   : sequencer FSM states (IDLE, SETTLE, INTEGRATE, OUTPUT)
//   - PHASE_*       : encoding of the calibration phase carried on result_tag
//   - sat_limit()   : largest magnitude a signed accumulator of a given width
//                     may hold (symmetric, so +/- limits have equal size)
// ---------------------------------------------------------------------------
package radiometer_cal_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SETTLE    = 2'd1,
        INTEGRATE = 2'd2,
        OUTPUT    = 2'd3
    } cal_state_t;

    localparam logic PHASE_ANTENNA = 1'b0;
    localparam logic PHASE_NOISE   = 1'b1;

    // Symmetric saturation bound: 2^(w-1)-1, so the most negative code is
    // never produced and the result can always be negated safely downstream.
    function automatic longint sat_limit(input int acc_w);
        return (longint'(1) << (acc_w - 1)) - longint'(1);
    endfunction

endpackage

// File: rtl/radiometer_cal_sequencer_if.sv
// ---------------------------------------------------------------------------
// radiometer_cal_sequencer_if
// Valid/ready result channel of the calibration sequencer.
//   result_valid : producer has a completed window result
//   result_ready : consumer accepts when valid && ready
//   result_data  : signed Dicke difference (ACC_W bits)
//   result_tag   : phase of the window, 0 = antenna, 1 = noise
// Modports: master (sequencer side), slave (consumer side).
// ---------------------------------------------------------------------------
interface radiometer_cal_sequencer_if #(
    parameter int ACC_W = 24
);
    logic                    result_valid;
    logic                    result_ready;
    logic signed [ACC_W-1:0] result_data;
    logic                    result_tag;

    modport master (
        output result_valid,
        output result_data,
        output result_tag,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_data,
        input  result_tag,
        output result_ready
    );
endinterface

// File: rtl/radiometer_dicke_accumulator.sv
// ---------------------------------------------------------------------------
// radiometer_dicke_accumulator
// Edge detector, switch-period counter and saturating up/down accumulator
// for one Dicke integration window.
//   clk, clr    : clock, asynchronous active-high reset
//   start       : one-cycle pulse, clears the window (counter, acc, arming)
//   enable      : high while the sequencer is integrating
//   switch_pwm  : Dicke switch reference
//   demod       : demodulated feed bit
//   window_done : combinational, high on the edge that closes the window
//   acc_value   : signed running difference, saturating at +/-(2^(ACC_W-1)-1)
// ---------------------------------------------------------------------------
module radiometer_dicke_accumulator
    import radiometer_cal_sequencer_pkg::*;
#(
    parameter int INTEG_PERIODS = 1024,
    parameter int ACC_W         = 24
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    start,
    input  logic                    enable,
    input  logic                    switch_pwm,
    input  logic                    demod,
    output logic                    window_done,
    output logic signed [ACC_W-1:0] acc_value
);

    localparam logic signed [ACC_W-1:0] ACC_MAX     = ACC_W'(sat_limit(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN     = -ACC_MAX;
    localparam logic        [15:0]      LAST_PERIOD = 16'(INTEG_PERIODS - 1);

    logic                    pwm_d;
    logic                    pwm_rise;
    logic                    armed;
    logic [15:0]             period_cnt;
    logic signed [ACC_W-1:0] acc_next;

    // The window is framed by switch edges: the first rising edge seen while
    // integrating arms the window (and is not counted), then the window runs
    // over whole switch periods and closes on the INTEG_PERIODS-th edge.
    // The closing edge sample belongs to the next period, so it is not added.
    assign pwm_rise    = switch_pwm & ~pwm_d;
    assign window_done = enable & armed & pwm_rise & (period_cnt == LAST_PERIOD);

    // Next accumulator value for this sample: +1 in the switch-high half,
    // -1 in the switch-low half, only when demod is set, clamped at the
    // symmetric limits instead of wrapping.
    always_comb begin
        acc_next = acc_value;
        if (demod) begin
            if (switch_pwm) begin
                if (acc_value != ACC_MAX) begin
                    acc_next = acc_value + ACC_W'(1);
                end
            end else if (acc_value != ACC_MIN) begin
                acc_next = acc_value - ACC_W'(1);
            end
        end
    end

    // Registered switch copy for edge detection, plus window arming, period
    // counting and accumulation. Outside integration everything holds, which
    // discards samples taken while the result is waiting for the consumer.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pwm_d      <= 1'b0;
            armed      <= 1'b0;
            period_cnt <= '0;
            acc_value  <= '0;
        end else begin
            pwm_d <= switch_pwm;
            if (start) begin
                armed      <= 1'b0;
                period_cnt <= '0;
                acc_value  <= '0;
            end else if (enable) begin
                if (!armed) begin
                    if (pwm_rise) begin
                        armed     <= 1'b1;
                        acc_value <= acc_next;
                    end
                end else if (!window_done) begin
                    if (pwm_rise) begin
                        period_cnt <= period_cnt + 16'd1;
                    end
                    acc_value <= acc_next;
                end
            end
        end
    end

endmodule

// File: rtl/radiometer_cal_sequencer.sv
// ---------------------------------------------------------------------------
// radiometer_cal_sequencer
// Sequences Dicke radiometer integration windows: settle after each phase
// change, integrate over INTEG_PERIODS switch periods, then hand the signed
// difference to the consumer over a valid/ready channel.
//   clk            : system clock
//   clr            : asynchronous active-high reset
//   run            : level, keep sequencing windows while high
//   switch_pwm     : Dicke switch reference (synchronous to clk)
//   demod          : demodulated feed bit (synchronous to clk)
//   noise_diode_en : calibration noise diode drive (registered)
//   busy           : high in every state except IDLE
//   result         : radiometer_cal_sequencer_if.master result channel
// Build option: define RADIOMETER_CAL_NOISE_EN to alternate antenna and
// noise-diode windows; without it every window is an antenna window,
// noise_diode_en and result_tag are tied low and no phase register exists.
// ---------------------------------------------------------------------------
module radiometer_cal_sequencer
    import radiometer_cal_sequencer_pkg::*;
#(
    parameter int INTEG_PERIODS = 1024,
    parameter int SETTLE_CYCLES = 64,
    parameter int ACC_W         = 24
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        run,
    input  logic                        switch_pwm,
    input  logic                        demod,
    output logic                        noise_diode_en,
    output logic                        busy,
    radiometer_cal_sequencer_if.master  result
);

    // A zero settle time still spends one cycle in SETTLE.
    localparam logic [15:0] SETTLE_LAST =
        (SETTLE_CYCLES == 0) ? 16'd0 : 16'(SETTLE_CYCLES - 1);

    cal_state_t              state;
    logic [15:0]             settle_cnt;
    logic                    window_start;
    logic                    window_done;
    logic                    handshake;
    logic signed [ACC_W-1:0] acc_value;

`ifdef RADIOMETER_CAL_NOISE_EN
    logic phase;
    logic next_phase;
    assign next_phase = (phase == PHASE_NOISE) ? PHASE_ANTENNA : PHASE_NOISE;
`else
    assign noise_diode_en     = 1'b0;
    assign result.result_tag  = PHASE_ANTENNA;
`endif

    // The accumulator is cleared on the last SETTLE cycle so it starts the
    // integration from zero.
    assign window_start = (state == SETTLE) && (settle_cnt == SETTLE_LAST);
    assign handshake    = result.result_valid && result.result_ready;

    radiometer_dicke_accumulator #(
        .INTEG_PERIODS (INTEG_PERIODS),
        .ACC_W         (ACC_W)
    ) u_accumulator (
        .clk         (clk),
        .clr         (clr),
        .start       (window_start),
        .enable      (state == INTEGRATE),
        .switch_pwm  (switch_pwm),
        .demod       (demod),
        .window_done (window_done),
        .acc_value   (acc_value)
    );

    // Sequencer FSM with registered outputs. run is only consulted in IDLE
    // and at the result handshake, so dropping it mid-window still lets the
    // window finish and be delivered. The result is captured once at window
    // close and held untouched until the consumer takes it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state               <= IDLE;
            settle_cnt          <= '0;
            busy                <= 1'b0;
            result.result_valid <= 1'b0;
            result.result_data  <= '0;
`ifdef RADIOMETER_CAL_NOISE_EN
            phase               <= PHASE_ANTENNA;
            noise_diode_en      <= 1'b0;
            result.result_tag   <= PHASE_ANTENNA;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
`ifdef RADIOMETER_CAL_NOISE_EN
                        noise_diode_en <= (phase == PHASE_NOISE);
`endif
                    end
                end
                SETTLE: begin
                    if (window_start) begin
                        state <= INTEGRATE;
                    end else begin
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end
                INTEGRATE: begin
                    if (window_done) begin
                        state               <= OUTPUT;
                        result.result_valid <= 1'b1;
                        result.result_data  <= acc_value;
`ifdef RADIOMETER_CAL_NOISE_EN
                        result.result_tag   <= phase;
`endif
                    end
                end
                OUTPUT: begin
                    if (handshake) begin
                        result.result_valid <= 1'b0;
                        if (run) begin
                            state      <= SETTLE;
                            settle_cnt <= '0;
`ifdef RADIOMETER_CAL_NOISE_EN
                            phase          <= next_phase;
                            noise_diode_en <= (next_phase == PHASE_NOISE);
`endif
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
`ifdef RADIOMETER_CAL_NOISE_EN
                            noise_diode_en <= 1'b0;
`endif
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_radiometer_cal_sequencer.sv
// ---------------------------------------------------------------------------
// tb_radiometer_cal_sequencer
// Self-checking bench for radiometer_cal_sequencer. Two instances share the
// clock, reset, switch reference and demod stream: a main one
// (INTEG_PERIODS=4, SETTLE_CYCLES=2, ACC_W=8) and a saturation one
// (INTEG_PERIODS=40). Honours RADIOMETER_CAL_NOISE_EN for tag expectations.
// ---------------------------------------------------------------------------
module tb_radiometer_cal_sequencer;

    localparam int M_N    = 4;
    localparam int M_S    = 2;
    localparam int LIM    = 127;
    localparam int MAXC   = 40000;
`ifdef RADIOMETER_CAL_NOISE_EN
    localparam int NOISE_ON = 1;
`else
    localparam int NOISE_ON = 0;
`endif

    typedef struct {
        int mode;
        bit sat;
        int nwin;
        int exp_data;
    } vec_t;

    logic       clk;
    logic       clr;
    logic       run_m, run_s;
    logic       ready_m, ready_s;
    logic       switch_pwm;
    logic       demod;
    logic       noise_m, noise_s;
    logic       busy_m, busy_s;
    logic [2:0] pwm_cnt;
    int         demod_mode;
    bit         rand_ready;
    int         cyc;
    int         checks;
    int         failures;

    logic pwm_h   [MAXC];
    logic demod_h [MAXC];
    logic run_h   [MAXC];
    logic ready_h [MAXC];

    radiometer_cal_sequencer_if #(.ACC_W(8)) res_m ();
    radiometer_cal_sequencer_if #(.ACC_W(8)) res_s ();

    assign res_m.result_ready = ready_m;
    assign res_s.result_ready = ready_s;

    radiometer_cal_sequencer #(
        .INTEG_PERIODS (M_N),
        .SETTLE_CYCLES (M_S),
        .ACC_W         (8)
    ) dut (
        .clk            (clk),
        .clr            (clr),
        .run            (run_m),
        .switch_pwm     (switch_pwm),
        .demod          (demod),
        .noise_diode_en (noise_m),
        .busy           (busy_m),
        .result         (res_m.master)
    );

    radiometer_cal_sequencer #(
        .INTEG_PERIODS (40),
        .SETTLE_CYCLES (M_S),
        .ACC_W         (8)
    ) dut_sat (
        .clk            (clk),
        .clr            (clr),
        .run            (run_s),
        .switch_pwm     (switch_pwm),
        .demod          (demod),
        .noise_diode_en (noise_s),
        .busy           (busy_s),
        .result         (res_s.master)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch reference (period 8, 50% duty), demod pattern and optional random
    // ready, all driven away from the active edge.
    always @(negedge clk) begin
        pwm_cnt    = pwm_cnt + 3'd1;
        switch_pwm = pwm_cnt[2];
        case (demod_mode)
            0:       demod = 1'b1;
            1:       demod = switch_pwm;
            2:       demod = ~switch_pwm;
            3:       demod = 1'b0;
            default: demod = 1'($urandom_range(0, 1));
        endcase
        if (rand_ready) ready_m = 1'($urandom_range(0, 1));
    end

    // Input history of the main instance, one entry per active edge, feeding
    // the reference model.
    always @(posedge clk) begin
        if (cyc < MAXC) begin
            pwm_h[cyc]   = switch_pwm;
            demod_h[cyc] = demod;
            run_h[cyc]   = run_m;
            ready_h[cyc] = ready_m;
        end
        cyc = cyc + 1;
    end

    // Hard stop if something never terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic bit rise_at(input int k);
        return pwm_h[k] && !pwm_h[k-1];
    endfunction

    // Reference model of one window launched at edge 'launch': integration
    // starts max(S,1)+1 edges later, the first rising edge arms the window,
    // and samples from it are summed (+1 switch high, -1 switch low, when
    // demod) with clamping until the M_N-th further rising edge closes it.
    function automatic void model_window(input int launch, input int hi,
                                         output int close_c, output int value);
        int s_eff;
        int arm;
        int cnt;
        s_eff   = (M_S == 0) ? 1 : M_S;
        close_c = -1;
        value   = 0;
        cnt     = 0;
        arm     = -1;
        for (int k = launch + s_eff + 1; k < hi; k++) begin
            if (rise_at(k)) begin
                arm = k;
                break;
            end
        end
        if (arm < 0) return;
        for (int k = arm; k < hi; k++) begin
            if (k > arm && rise_at(k)) begin
                cnt++;
                if (cnt == M_N) begin
                    close_c = k;
                    break;
                end
            end
            if (demod_h[k]) begin
                value = value + (pwm_h[k] ? 1 : -1);
                if (value > LIM)  value = LIM;
                if (value < -LIM) value = -LIM;
            end
        end
    endfunction

    function automatic int exp_tag(input int w);
        return (w % 2) * NOISE_ON;
    endfunction

    function automatic logic get_valid(input bit sat);
        return sat ? res_s.result_valid : res_m.result_valid;
    endfunction

    function automatic int get_data(input bit sat);
        return sat ? int'(res_s.result_data) : int'(res_m.result_data);
    endfunction

    function automatic int get_tag(input bit sat);
        return sat ? int'(res_s.result_tag) : int'(res_m.result_tag);
    endfunction

    function automatic int get_busy(input bit sat);
        return sat ? int'(busy_s) : int'(busy_m);
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int mode, input bit sat, input bit run_v, input bit ready_v);
        @(negedge clk);
        demod_mode = mode;
        if (sat) begin
            run_s   = run_v;
            ready_s = ready_v;
        end else begin
            run_m   = run_v;
            ready_m = ready_v;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        clr        = 1'b1;
        run_m      = 1'b0;
        run_s      = 1'b0;
        ready_m    = 1'b0;
        ready_s    = 1'b1;
        rand_ready = 1'b0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic waitLevel(input bit sat, input logic level, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < max_cyc; t++) begin
            @(negedge clk);
            if (get_valid(sat) == level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        vec_t vecs[7];
        bit   ok;
        bit   stable;
        bit   rose;
        int   hold_data;
        int   hold_tag;
        int   launch;
        int   c_obs, c_exp, v_exp;
        int   h, h_exp;
        int   tag_exp;

        clr        = 1'b1;
        run_m      = 1'b0;
        run_s      = 1'b0;
        ready_m    = 1'b0;
        ready_s    = 1'b1;
        pwm_cnt    = 3'd0;
        switch_pwm = 1'b0;
        demod      = 1'b0;
        demod_mode = 3;
        rand_ready = 1'b0;
        cyc        = 0;
        checks     = 0;
        failures   = 0;

        //            mode sat nwin exp_data
        vecs[0] = '{0, 1'b0, 1,    0};
        vecs[1] = '{1, 1'b0, 3,   16};
        vecs[2] = '{2, 1'b0, 2,  -16};
        vecs[3] = '{3, 1'b0, 1,    0};
        vecs[4] = '{1, 1'b1, 1,  127};
        vecs[5] = '{2, 1'b1, 1, -127};
        vecs[6] = '{0, 1'b1, 1,    0};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_valid", res_m.result_valid, 0);
        checkOutput("rst_data",  get_data(0), 0);
        checkOutput("rst_tag",   res_m.result_tag, 0);
        checkOutput("rst_busy",  busy_m, 0);
        checkOutput("rst_noise", noise_m, 0);
        checkOutput("rst_sat_busy", busy_s, 0);
        clr = 1'b0;

        // busy rises the cycle after run.
        @(negedge clk);
        checkOutput("idle_busy", busy_m, 0);
        applyStimulus(1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("busy_after_run", busy_m, 1);

        // Table-driven windows.
        for (int v = 0; v < 7; v++) begin
            doReset();
            applyStimulus(vecs[v].mode, vecs[v].sat, 1'b1, 1'b1);
            for (int w = 0; w < vecs[v].nwin; w++) begin
                waitLevel(vecs[v].sat, 1'b1, 1000, ok);
                checkOutput("vec_valid_timeout", ok, 1);
                if (!ok) break;
                checkOutput("vec_data", get_data(vecs[v].sat), vecs[v].exp_data);
                checkOutput("vec_tag",  get_tag(vecs[v].sat),  exp_tag(w));
                if (!vecs[v].sat) checkOutput("vec_noise", noise_m, exp_tag(w));
                if (w == vecs[v].nwin - 1) begin
                    if (vecs[v].sat) run_s = 1'b0;
                    else             run_m = 1'b0;
                end
                waitLevel(vecs[v].sat, 1'b0, 20, ok);
                checkOutput("vec_handshake_timeout", ok, 1);
            end
            @(negedge clk);
            checkOutput("vec_idle_busy", get_busy(vecs[v].sat), 0);
        end

        // Backpressure: result held for 50 cycles, then exactly one handshake.
        doReset();
        applyStimulus(1, 1'b0, 1'b1, 1'b0);
        waitLevel(1'b0, 1'b1, 200, ok);
        checkOutput("bp_valid_timeout", ok, 1);
        hold_data = get_data(0);
        hold_tag  = get_tag(0);
        stable    = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!res_m.result_valid || get_data(0) != hold_data ||
                get_tag(0) != hold_tag || !busy_m) stable = 1'b0;
        end
        checkOutput("bp_stable", stable, 1);
        checkOutput("bp_data", hold_data, 16);
        ready_m = 1'b1;
        @(negedge clk);
        checkOutput("bp_valid_drop", res_m.result_valid, 0);
        ready_m = 1'b0;
        rose    = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (res_m.result_valid) rose = 1'b1;
        end
        checkOutput("bp_single_handshake", rose, 0);

        // run dropped mid-integration: window still delivered, then IDLE.
        doReset();
        applyStimulus(1, 1'b0, 1'b1, 1'b1);
        repeat (12) @(negedge clk);
        run_m = 1'b0;
        waitLevel(1'b0, 1'b1, 200, ok);
        checkOutput("drop_valid_timeout", ok, 1);
        checkOutput("drop_data", get_data(0), 16);
        waitLevel(1'b0, 1'b0, 20, ok);
        checkOutput("drop_handshake_timeout", ok, 1);
        checkOutput("drop_busy", busy_m, 0);
        rose = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (res_m.result_valid || busy_m) rose = 1'b1;
        end
        checkOutput("drop_stays_idle", rose, 0);

        // Reset while a result is pending.
        doReset();
        applyStimulus(1, 1'b0, 1'b1, 1'b0);
        waitLevel(1'b0, 1'b1, 200, ok);
        checkOutput("clr_valid_timeout", ok, 1);
        @(negedge clk);
        clr = 1'b1;
        #1;
        checkOutput("clr_valid", res_m.result_valid, 0);
        checkOutput("clr_data",  get_data(0), 0);
        checkOutput("clr_tag",   res_m.result_tag, 0);
        checkOutput("clr_busy",  busy_m, 0);
        checkOutput("clr_noise", noise_m, 0);
        @(negedge clk);
        clr     = 1'b0;
        ready_m = 1'b1;
        waitLevel(1'b0, 1'b1, 200, ok);
        checkOutput("clr_next_timeout", ok, 1);
        checkOutput("clr_next_tag",  get_tag(0), 0);
        checkOutput("clr_next_data", get_data(0), 16);
        run_m = 1'b0;
        waitLevel(1'b0, 1'b0, 20, ok);

        // Randomized demod and ready against the reference model.
        doReset();
        applyStimulus(4, 1'b0, 1'b1, 1'b0);
        launch     = cyc;
        rand_ready = 1'b1;
        tag_exp    = 0;
        for (int w = 0; w < 6; w++) begin
            waitLevel(1'b0, 1'b1, 500, ok);
            checkOutput("rnd_valid_timeout", ok, 1);
            if (!ok) break;
            c_obs = cyc - 1;
            model_window(launch, cyc, c_exp, v_exp);
            checkOutput("rnd_close_cycle", c_obs, c_exp);
            checkOutput("rnd_data",  get_data(0), v_exp);
            checkOutput("rnd_tag",   get_tag(0), tag_exp);
            checkOutput("rnd_noise", noise_m, tag_exp);
            if (w == 5) run_m = 1'b0;
            hold_data = get_data(0);
            hold_tag  = get_tag(0);
            stable    = 1'b1;
            ok        = 1'b0;
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                if (!res_m.result_valid) begin
                    ok = 1'b1;
                    break;
                end
                if (get_data(0) != hold_data || get_tag(0) != hold_tag) stable = 1'b0;
            end
            checkOutput("rnd_handshake_timeout", ok, 1);
            checkOutput("rnd_hold", stable, 1);
            if (!ok) break;
            h     = cyc - 1;
            h_exp = -1;
            for (int k = c_obs + 1; k <= h; k++) begin
                if (ready_h[k]) begin
                    h_exp = k;
                    break;
                end
            end
            checkOutput("rnd_handshake_cycle", h, h_exp);
            if (run_h[h]) begin
                launch  = h;
                tag_exp = tag_exp ^ NOISE_ON;
            end
        end
        rand_ready = 1'b0;
        checkOutput("rnd_idle_busy", busy_m, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
